// File: rtl/load_store_unit.sv
// load_store_unit: formats execute-stage memory ops into dmem requests and aligns load results
module load_store_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_valid,
  input  logic [1:0]  exe_fcn,
  input  logic [2:0]  exe_typ,
  input  logic [31:0] exe_addr,
  input  logic [31:0] exe_wdata,
  input  logic        pipeline_kill,
  output logic        exe_ready,
  output logic [68:0] dmem_req,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  input  logic        dmem_res_valid,
  input  logic [31:0] dmem_res_data,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        stall
);
  localparam logic [1:0] M_XRD = 2'd0;
  localparam logic [1:0] M_X   = 2'd2;
  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_BU = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_HU = 3'd3;
  localparam logic [2:0] MT_W  = 3'd4;
  localparam logic [2:0] MT_WU = 3'd5;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t      state, state_nxt;
  logic [31:0] req_addr, req_data, st_data, ld_data, byte_w, half_w;
  logic [1:0]  req_fcn;
  logic [2:0]  req_typ;
  logic        accept, mis, issue, is_load, complete;
  // Decode the incoming op and shape store data / load result into their lanes
  always_comb begin
    accept   = exe_valid & exe_ready & ~pipeline_kill;
    mis      = CHECK_ALIGN && (((exe_typ == MT_H || exe_typ == MT_HU) && exe_addr[0]) ||
                               ((exe_typ == MT_W || exe_typ == MT_WU) && exe_addr[1:0] != 2'd0));
    issue    = accept && exe_fcn != M_X && !mis;
    is_load  = req_fcn == M_XRD;
    complete = dmem_res_valid & ~pipeline_kill & is_load &
               ((state == REQ & dmem_req_ready) | state == WAIT);
    st_data  = (exe_typ == MT_B || exe_typ == MT_BU) ? {24'd0, exe_wdata[7:0]} << {exe_addr[1:0], 3'b000} :
               (exe_typ == MT_H || exe_typ == MT_HU) ? {16'd0, exe_wdata[15:0]} << {exe_addr[1], 4'b0000} :
               exe_wdata;
    byte_w   = dmem_res_data >> {req_addr[1:0], 3'b000};
    half_w   = dmem_res_data >> {req_addr[1], 4'b0000};
    ld_data  = req_typ == MT_B  ? {{24{byte_w[7]}}, byte_w[7:0]} :
               req_typ == MT_BU ? {24'd0, byte_w[7:0]} :
               req_typ == MT_H  ? {{16{half_w[15]}}, half_w[15:0]} :
               req_typ == MT_HU ? {16'd0, half_w[15:0]} :
               dmem_res_data;
  end
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // Next-state logic; a kill after the memory took a load must still drain its response
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = issue ? REQ : IDLE;
      REQ:   state_nxt = dmem_req_ready ? ((is_load && !dmem_res_valid) ? (pipeline_kill ? DRAIN : WAIT) : IDLE) :
                         pipeline_kill ? IDLE : REQ;
      WAIT:  state_nxt = dmem_res_valid ? IDLE : pipeline_kill ? DRAIN : WAIT;
      DRAIN: state_nxt = dmem_res_valid ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  // Outputs derived from state and the held request
  always_comb begin
    exe_ready      = state == IDLE;
    dmem_req_valid = state == REQ;
    stall          = (exe_valid & ~exe_ready) | (state != IDLE);
    dmem_req       = {req_addr, req_data, req_fcn, req_typ};
  end
  // Request capture, writeback and exception pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr   <= '0;
      req_data   <= '0;
      req_fcn    <= '0;
      req_typ    <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      misaligned <= 1'b0;
    end else begin
      if (issue) begin
        req_addr <= exe_addr;
        req_data <= st_data;
        req_fcn  <= exe_fcn;
        req_typ  <= exe_typ;
      end
      wb_valid   <= complete;
      if (complete) wb_data <= ld_data;
      misaligned <= accept && exe_fcn != M_X && mis;
    end
  end
endmodule
